// File: rtl/rv32i_types_pkg.sv
// Shared types for the core context swap unit.
//   swap_state_t : states of the swap controller
//   NUM_REGS     : architectural integer registers per file (x0 included)
//   SWAP_LATENCY : cycles from an accepted swap request to stall release
package rv32i_types;

    localparam int NUM_REGS     = 32;
    localparam int SWAP_LATENCY = NUM_REGS + 3;

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        DRAIN,
        PC_LOAD,
        DONE
    } swap_state_t;

endpackage

// File: rtl/core_context_swap_unit_xfer_sequencer.sv
// Register transfer sequencer for the context swap unit.
// Walks the transfer index 1..NUM_REGS-1 while active, and keeps a
// one-cycle delayed copy of the index and a valid flag. Writes use the
// delayed index so they line up with the 1-cycle regfile read latency.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : load the index with 1 (accepted swap request)
//   active     : controller is issuing reads this cycle
//   idx        : current read index
//   idx_last   : idx is the final register (NUM_REGS-1)
//   idx_d      : read index of the previous cycle (write index)
//   valid_d    : a read was issued last cycle, so write this cycle
module swap_xfer_sequencer #(
    parameter int NUM_REGS  = 32,
    parameter int RF_ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 active,
    output logic [RF_ADDR_W-1:0] idx,
    output logic                 idx_last,
    output logic [RF_ADDR_W-1:0] idx_d,
    output logic                 valid_d
);

    // Terminal compare stops the counter at NUM_REGS-1, so it never wraps.
    assign idx_last = (idx == RF_ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            idx_d   <= '0;
            valid_d <= 1'b0;
        end else begin
            if (start) begin
                // x0 is never transferred, so the walk starts at 1.
                idx <= RF_ADDR_W'(1);
            end else if (active && !idx_last) begin
                idx <= idx + RF_ADDR_W'(1);
            end
            valid_d <= active;
            idx_d   <= active ? idx : '0;
        end
    end

endmodule

// File: rtl/core_context_swap_unit.sv
// Core context swap unit.
// On a swap request from the scheduler, stalls both cores, crosses x1..x31
// between the OOO and pipelined register files, swaps the two fetch PCs,
// then releases the cores and flips the thread-to-core mapping.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for swap_req, cores running
// XFER    | issuing reads for x1..x31, writes trail by one cycle
// DRAIN   | final write (x31) from the last read
// PC_LOAD | both PCs overwritten with the other core's PC
// DONE    | completion pulse, mapping flips, swap counter increments
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   swap_req                  : swap strobe, sampled only in IDLE
//   ooo_pc, ppl_pc            : current fetch PCs of both cores
//   ooo/ppl_rf_raddr, _rdata  : transfer read ports (1-cycle latency)
//   ooo/ppl_rf_we/waddr/wdata : transfer write ports
//   ooo/ppl_pc_load, _val     : PC overwrite strobes and values
//   core_stall, swap_busy     : swap in progress (cores frozen)
//   swap_done                 : one-cycle completion pulse
//   thread_map                : 0 = thread A on OOO, 1 = thread A on PPL
//   swap_count                : completed swaps, saturating
module core_context_swap_unit #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int RF_ADDR_W  = $clog2(NUM_REGS),
    parameter int SWAP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  swap_req,
    input  logic [XLEN-1:0]       ooo_pc,
    input  logic [XLEN-1:0]       ppl_pc,
    output logic [RF_ADDR_W-1:0]  ooo_rf_raddr,
    input  logic [XLEN-1:0]       ooo_rf_rdata,
    output logic [RF_ADDR_W-1:0]  ppl_rf_raddr,
    input  logic [XLEN-1:0]       ppl_rf_rdata,
    output logic                  ooo_rf_we,
    output logic [RF_ADDR_W-1:0]  ooo_rf_waddr,
    output logic [XLEN-1:0]       ooo_rf_wdata,
    output logic                  ppl_rf_we,
    output logic [RF_ADDR_W-1:0]  ppl_rf_waddr,
    output logic [XLEN-1:0]       ppl_rf_wdata,
    output logic                  ooo_pc_load,
    output logic [XLEN-1:0]       ooo_pc_load_val,
    output logic                  ppl_pc_load,
    output logic [XLEN-1:0]       ppl_pc_load_val,
    output logic                  core_stall,
    output logic                  swap_busy,
    output logic                  swap_done,
    output logic                  thread_map,
    output logic [SWAP_CNT_W-1:0] swap_count
);

    import rv32i_types::*;

    swap_state_t          state;
    swap_state_t          state_nxt;
    logic [RF_ADDR_W-1:0] idx;
    logic [RF_ADDR_W-1:0] idx_d;
    logic                 idx_last;
    logic                 valid_d;
    logic                 start;
    logic                 in_xfer;

    assign start   = (state == IDLE) && swap_req;
    assign in_xfer = (state == XFER);

    swap_xfer_sequencer #(
        .NUM_REGS  (NUM_REGS),
        .RF_ADDR_W (RF_ADDR_W)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .active   (in_xfer),
        .idx      (idx),
        .idx_last (idx_last),
        .idx_d    (idx_d),
        .valid_d  (valid_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (swap_req) state_nxt = XFER;
            XFER:    if (idx_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = PC_LOAD;
            PC_LOAD: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_stall      = (state != IDLE);
        swap_busy       = (state != IDLE);
        swap_done       = (state == DONE);

        ooo_rf_raddr    = in_xfer ? idx : '0;
        ppl_rf_raddr    = in_xfer ? idx : '0;

        // Writes trail reads by one cycle; the write at i-1 never touches
        // the register being read at i, so all read data is pre-swap.
        ooo_rf_we       = valid_d;
        ppl_rf_we       = valid_d;
        ooo_rf_waddr    = valid_d ? idx_d : '0;
        ppl_rf_waddr    = valid_d ? idx_d : '0;
        ooo_rf_wdata    = valid_d ? ppl_rf_rdata : '0;
        ppl_rf_wdata    = valid_d ? ooo_rf_rdata : '0;

        // PCs are frozen by the stall, so sampling them live is safe here.
        ooo_pc_load     = (state == PC_LOAD);
        ppl_pc_load     = (state == PC_LOAD);
        ooo_pc_load_val = (state == PC_LOAD) ? ppl_pc : '0;
        ppl_pc_load_val = (state == PC_LOAD) ? ooo_pc : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thread_map <= 1'b0;
            swap_count <= '0;
        end else if (state == DONE) begin
            thread_map <= ~thread_map;
            if (swap_count != '1) begin
                swap_count <= swap_count + SWAP_CNT_W'(1);
            end
        end
    end

endmodule
